text_renderer: RTL and testbench

TEXT_RENDERER -- requirements
Module: text_renderer

---
 rtl/text_renderer.sv | 200 ++++++++++++++++++++
 tb/tb_text_renderer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_renderer.sv
// text_renderer: character-cell text overlay for a VGA-style raster.
//
// Each 8x16 cell fetches a character code from an external character RAM and a
// glyph row from an external font ROM. A 3-cycle pipeline turns the incoming
// timing counters into registered RGB444 pixels and registered output syncs.
// A blinking block cursor swaps the foreground and background colours of
// one cell.
//
// Ports:
//   pix_clk              pixel clock, the only clock
//   rst                  synchronous active-low reset
//   H_count, V_count     raster counters from the timing generator
//   H_sync, V_sync       1 = inside sync pulse
//   H_active, V_active   1 = inside visible region
//   char_addr/char_data  character RAM port (data valid one cycle after the address)
//   font_addr/font_data  font ROM port {code, glyph row}; data MSB = leftmost pixel
//   fg_color, bg_color   RGB444 text colours
//   cursor_en/col/row    cursor enable and cell position
//   vga_r/g/b, vga_hs/vs registered pixel colour and syncs
module text_renderer #(
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter bit          SYNC_POL     = 1'b0
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic [11:0] H_count,
  input  logic [11:0] V_count,
  input  logic        H_sync,
  input  logic        V_sync,
  input  logic        H_active,
  input  logic        V_active,
  output logic [11:0] char_addr,
  input  logic [7:0]  char_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [11:0] fg_color,
  input  logic [11:0] bg_color,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam int unsigned FcW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FcW-1:0] FcLast = FcW'(BLINK_FRAMES - 1);
  localparam logic       SyncIdle = !SYNC_POL;

  if ((COLS * ROWS > 4096) || (BLINK_FRAMES < 1)) begin : g_param_check
    $error("text_renderer: COLS*ROWS must not exceed 4096 and BLINK_FRAMES must be >= 1");
  end

  // Stage 0 decode of the raster position
  logic [6:0]  col;
  logic [2:0]  px;
  logic [4:0]  row;
  logic [3:0]  gy;
  logic        visible;
  logic        in_grid;
  logic        frame_start;
  logic        cursor_hit;
  logic [11:0] cell_addr;
  logic        unused_bits;

  assign col         = H_count[9:3];
  assign px          = H_count[2:0];
  assign row         = V_count[8:4];
  assign gy          = V_count[3:0];
  assign visible     = H_active & V_active;
  assign in_grid     = (32'(col) < COLS) && (32'(row) < ROWS);
  assign frame_start = (H_count == 12'd0) && (V_count == 12'd0);
  assign cell_addr   = 12'(row) * 12'(COLS) + 12'(col);
  assign unused_bits = ^{H_count[11:10], V_count[11:9]};

  // Blink timing
  logic [FcW-1:0] frame_cnt_q, frame_cnt_d;
  logic           blink_on_q, blink_on_d;

  assign cursor_hit = cursor_en & blink_on_q & (col == cursor_col) & (row == cursor_row);

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_start) begin
      if (frame_cnt_q == FcLast) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FcW'(1);
      end
    end
  end

  always_ff @(posedge pix_clk) begin
    if (!rst) begin
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  // Pipeline registers: stage 0 (address + sideband), stage 1 (font address + sideband)
  logic [3:0]  gy0_q;
  logic [2:0]  px0_q, px1_q;
  logic        hs0_q, hs1_q, vs0_q, vs1_q;
  logic        vis0_q, vis1_q, grid0_q, grid1_q, hit0_q, hit1_q;
  logic [11:0] fg0_q, fg1_q, bg0_q, bg1_q;
  logic [11:0] char_addr_q, font_addr_q;

  always_ff @(posedge pix_clk) begin
    if (!rst) begin
      char_addr_q <= '0;
      gy0_q       <= '0;
      px0_q       <= '0;
      hs0_q       <= 1'b0;
      vs0_q       <= 1'b0;
      vis0_q      <= 1'b0;
      grid0_q     <= 1'b0;
      hit0_q      <= 1'b0;
      fg0_q       <= '0;
      bg0_q       <= '0;
      font_addr_q <= '0;
      px1_q       <= '0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      vis1_q      <= 1'b0;
      grid1_q     <= 1'b0;
      hit1_q      <= 1'b0;
      fg1_q       <= '0;
      bg1_q       <= '0;
    end else begin
      char_addr_q <= (visible && in_grid) ? cell_addr : 12'd0;
      gy0_q       <= gy;
      px0_q       <= px;
      hs0_q       <= H_sync;
      vs0_q       <= V_sync;
      vis0_q      <= visible;
      grid0_q     <= in_grid;
      hit0_q      <= cursor_hit;
      fg0_q       <= fg_color;
      bg0_q       <= bg_color;
      font_addr_q <= {char_data, gy0_q};
      px1_q       <= px0_q;
      hs1_q       <= hs0_q;
      vs1_q       <= vs0_q;
      vis1_q      <= vis0_q;
      grid1_q     <= grid0_q;
      hit1_q      <= hit0_q;
      fg1_q       <= fg0_q;
      bg1_q       <= bg0_q;
    end
  end

  assign char_addr = char_addr_q;
  assign font_addr = font_addr_q;

  // Stage 2: pixel select and colour choice; a cursor hit inverts the pixel sense
  logic        pix;
  logic [11:0] rgb_d;

  assign pix = font_data[3'd7 - px1_q];

  always_comb begin
    rgb_d = 12'h000;
    if (vis1_q) begin
      if (!grid1_q) begin
        rgb_d = bg1_q;
      end else if (pix ^ hit1_q) begin
        rgb_d = fg1_q;
      end else begin
        rgb_d = bg1_q;
      end
    end
  end

  // Stage 3: output registers
  always_ff @(posedge pix_clk) begin
    if (!rst) begin
      vga_r  <= 4'h0;
      vga_g  <= 4'h0;
      vga_b  <= 4'h0;
      vga_hs <= SyncIdle;
      vga_vs <= SyncIdle;
    end else begin
      vga_r  <= rgb_d[11:8];
      vga_g  <= rgb_d[7:4];
      vga_b  <= rgb_d[3:0];
      vga_hs <= hs1_q ^ SyncIdle;
      vga_vs <= vs1_q ^ SyncIdle;
    end
  end

endmodule

// File: tb/tb_text_renderer.sv
// Self-checking bench for text_renderer: directed checks of the addressing,
// pixel, sync and cursor-blink behaviour, then randomized rasters compared
// cycle by cycle against a reference model of the rendered picture.
module tb_text_renderer;

  localparam int BF = 2;

  logic        pix_clk;
  logic        rst;
  logic [11:0] H_count, V_count;
  logic        H_sync, V_sync, H_active, V_active;
  logic [11:0] char_addr, font_addr;
  logic [7:0]  char_data, font_data;
  logic [11:0] fg_color, bg_color;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs;

  logic [7:0] char_mem [4096];
  logic [7:0] font_mem [4096];

  assign char_data = char_mem[char_addr];
  assign font_data = font_mem[font_addr];

  text_renderer #(
    .COLS        (80),
    .ROWS        (30),
    .BLINK_FRAMES(BF),
    .SYNC_POL    (1'b0)
  ) u_dut (
    .pix_clk   (pix_clk),
    .rst       (rst),
    .H_count   (H_count),
    .V_count   (V_count),
    .H_sync    (H_sync),
    .V_sync    (V_sync),
    .H_active  (H_active),
    .V_active  (V_active),
    .char_addr (char_addr),
    .char_data (char_data),
    .font_addr (font_addr),
    .font_data (font_data),
    .fg_color  (fg_color),
    .bg_color  (bg_color),
    .cursor_en (cursor_en),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .vga_r     (vga_r),
    .vga_g     (vga_g),
    .vga_b     (vga_b),
    .vga_hs    (vga_hs),
    .vga_vs    (vga_vs)
  );

  initial pix_clk = 1'b0;
  always #5 pix_clk = ~pix_clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the screen should show for the inputs seen at one edge.
  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  localparam exp_t RstExp = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};

  exp_t hist [3];
  int   pulses;

  function automatic exp_t render(input bit blink);
    exp_t e;
    int c, r, p, g;
    bit vis, grid, hit, on;
    logic [7:0] code, glyph;
    c = int'(H_count[9:3]);
    p = int'(H_count[2:0]);
    r = int'(V_count[8:4]);
    g = int'(V_count[3:0]);
    vis  = H_active && V_active;
    grid = (c < 80) && (r < 30);
    hit  = cursor_en && blink && (c == int'(cursor_col)) && (r == int'(cursor_row));
    e.hs = !H_sync;
    e.vs = !V_sync;
    if (!vis) begin
      e.rgb = 12'h000;
    end else if (!grid) begin
      e.rgb = bg_color;
    end else begin
      code  = char_mem[r * 80 + c];
      glyph = font_mem[int'(code) * 16 + g];
      on    = glyph[7 - p];
      e.rgb = (on != hit) ? fg_color : bg_color;
    end
    return e;
  endfunction

  // Cursor is lit while the number of frame starts seen since reset, divided by BF, is even.
  always @(posedge pix_clk) begin
    if (!rst) begin
      pulses  <= 0;
      hist[0] <= RstExp;
      hist[1] <= RstExp;
      hist[2] <= RstExp;
    end else begin
      hist[0] <= render(((pulses / BF) % 2) == 0);
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      if (H_count == 12'd0 && V_count == 12'd0) pulses <= pulses + 1;
    end
  end

  always @(negedge pix_clk) begin
    check("pixel_rgb", 32'({vga_r, vga_g, vga_b}), 32'(hist[2].rgb));
    check("pixel_sync", 32'({vga_hs, vga_vs}), 32'({hist[2].hs, hist[2].vs}));
  end

  task automatic put(input logic [11:0] h, input logic [11:0] v, input logic act);
    H_count  = h;
    V_count  = v;
    H_active = act;
    V_active = act;
  endtask

  int first_low, lows;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      char_mem[i] = 8'($urandom);
      font_mem[i] = 8'($urandom);
    end
    char_mem[162]   = 8'h41;
    font_mem['h415] = 8'h80;
    char_mem[0]     = 8'h20;
    font_mem['h203] = 8'h00;

    rst = 1'b0;
    put(12'd0, 12'd0, 1'b0);
    H_sync = 1'b0; V_sync = 1'b0;
    fg_color = 12'hFFF; bg_color = 12'h000;
    cursor_en = 1'b0; cursor_col = 7'd0; cursor_row = 5'd0;

    repeat (3) @(negedge pix_clk);
    check("reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    check("reset_hs", 32'(vga_hs), 32'h1);
    check("reset_vs", 32'(vga_vs), 32'h1);
    check("reset_char_addr", 32'(char_addr), 32'h0);
    check("reset_font_addr", 32'(font_addr), 32'h0);
    rst = 1'b1;

    // Cell (2,2), glyph row 5, pixel 0
    @(negedge pix_clk);
    put(12'd16, 12'd37, 1'b1);
    @(negedge pix_clk);
    check("char_addr_cell_2_2", 32'(char_addr), 32'd162);
    @(negedge pix_clk);
    check("font_addr_41_5", 32'(font_addr), 32'h415);
    @(negedge pix_clk);
    check("glyph_px0_fg", 32'({vga_r, vga_g, vga_b}), 32'hFFF);
    put(12'd17, 12'd37, 1'b1);
    repeat (3) @(negedge pix_clk);
    check("glyph_px1_bg", 32'({vga_r, vga_g, vga_b}), 32'h000);

    // Blanking and right-of-grid area
    bg_color = 12'hA5C;
    H_active = 1'b0;
    repeat (3) @(negedge pix_clk);
    check("blank_black", 32'({vga_r, vga_g, vga_b}), 32'h000);
    put(12'd640, 12'd37, 1'b1);
    repeat (3) @(negedge pix_clk);
    check("off_grid_bg", 32'({vga_r, vga_g, vga_b}), 32'hA5C);

    // 96-cycle horizontal sync pulse
    H_sync = 1'b1;
    first_low = -1;
    lows = 0;
    for (int i = 1; i <= 110; i++) begin
      @(negedge pix_clk);
      if (!vga_hs) begin
        lows++;
        if (first_low < 0) first_low = i;
      end
      if (i == 96) H_sync = 1'b0;
    end
    check("hsync_width", 32'(lows), 32'd96);
    check("hsync_delay", 32'(first_low), 32'd3);

    // Cursor blink at cell (0,0): frames 0,1 inverted, 2,3 normal, 4 inverted
    rst = 1'b0;
    put(12'd300, 12'd200, 1'b1);
    @(negedge pix_clk);
    rst = 1'b1;
    fg_color = 12'h123; bg_color = 12'h456;
    cursor_en = 1'b1; cursor_col = 7'd0; cursor_row = 5'd0;
    for (int f = 0; f <= 4; f++) begin
      if (f > 0) begin
        put(12'd0, 12'd0, 1'b0);
        @(negedge pix_clk);
      end
      put(12'd3, 12'd3, 1'b1);
      repeat (3) @(negedge pix_clk);
      check($sformatf("blink_frame%0d", f), 32'({vga_r, vga_g, vga_b}),
            (f == 2 || f == 3) ? 32'h456 : 32'h123);
    end

    // Randomized rasters
    for (int n = 0; n < 4000; n++) begin
      @(negedge pix_clk);
      rst = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) fg_color = 12'($urandom);
      if ($urandom_range(0, 3) == 0) bg_color = 12'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        cursor_en  = 1'($urandom);
        cursor_col = 7'($urandom_range(0, 79));
        cursor_row = 5'($urandom_range(0, 29));
      end
      if ($urandom_range(0, 9) == 0) H_sync = ~H_sync;
      if ($urandom_range(0, 19) == 0) V_sync = ~V_sync;
      case ($urandom_range(0, 9))
        0: put(12'd0, 12'd0, 1'b1);
        1, 2: put({2'b00, cursor_col, 3'($urandom)}, {3'b000, cursor_row, 4'($urandom)}, 1'b1);
        default: begin
          H_count  = 12'($urandom_range(0, 799));
          V_count  = 12'($urandom_range(0, 524));
          H_active = (H_count < 12'd640) ^ ($urandom_range(0, 9) == 0);
          V_active = (V_count < 12'd480) ^ ($urandom_range(0, 9) == 0);
        end
      endcase
    end

    // Reset in mid-frame restarts the blink phase lit
    @(negedge pix_clk);
    rst = 1'b1;
    put(12'd400, 12'd250, 1'b1);
    @(negedge pix_clk);
    rst = 1'b0;
    @(negedge pix_clk);
    check("midframe_reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    check("midframe_reset_sync", 32'({vga_hs, vga_vs}), 32'h3);
    rst = 1'b1;
    fg_color = 12'h123; bg_color = 12'h456;
    cursor_en = 1'b1; cursor_col = 7'd0; cursor_row = 5'd0;
    put(12'd3, 12'd3, 1'b1);
    repeat (3) @(negedge pix_clk);
    check("midframe_reset_blink_on", 32'({vga_r, vga_g, vga_b}), 32'h123);

    @(negedge pix_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
